mem_responder: RTL and testbench
================================

# mem_responder

Behavioural memory responder for the LSQ memory port: it accepts the load/store commands the LSQ issues, answers each accepted command in the same cycle with a nonzero transaction tag, and returns the completion a fixed `LATENCY` cycles later on the tagged response bus. It backs a `DEPTH`-doubleword array and is used in unit and integration benches in place of the real memory system. It is synthesizable and is the responder side of the `mem_address_o` / `mem_command_o` / `mem_wdata_o` / `mem_size_o` interface.

## Interface
- `DEPTH`, 256: number of 64-bit doublewords stored; must be a power of 2.
- `LATENCY`, 4: cycles from acceptance to completion; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_command_i`  in  2  command: 0 NONE, 1 LOAD, 2 STORE, 3 reserved.
- `mem_address_i`  in  `XLEN`  byte address.
- `mem_wdata_i`  in  64  store data, right-aligned (the byte/half/word sits in the low bits).
- `mem_size_i`  in  3  size: 0 BYTE, 1 HALF, 2 WORD, 3 DOUBLE; 4..7 illegal.
- `mem_response_o`  out  4  combinational; tag of the accepted command, 0 = rejected or idle.
- `mem_valid_o`  out  1  registered completion strobe.
- `mem_tag_o`  out  4  tag of the completing command; 0 when `mem_valid_o` = 0.
- `mem_data_o`  out  64  load data: the full aligned doubleword. 0 for stores and when idle.

## Operation
- **Indexing.** Index = `mem_address_i[3 +: log2(DEPTH)]`. Higher address bits are ignored, so addresses wrap. Byte offset = `mem_address_i[2:0]`.
- **Rejection.** A command is rejected (response 0, no state change, no completion) if any of the following holds:
  - command is NONE or 3;
  - size is greater than 3;
  - the access is misaligned (offset not a multiple of 2^size);
  - the stall logic fires (see Configuration).
- **Acceptance.** An accepted command takes the tag from `next_tag`. `next_tag` counts 1..15 and wraps 15→1; tag 0 is never issued. Outstanding commands never exceed `LATENCY` ≤ 15, so no tag is in use twice.
- **Store.**
  - At the acceptance edge, the low 2^size bytes of `mem_wdata_i` are merged into the doubleword at byte lanes offset..offset+2^size-1.
  - The other lanes are unchanged.
  - The completion carries data 0.
- **Load.** The doubleword is snapshotted at the acceptance edge and delivered unmodified at completion. Sub-doubleword extraction and sign extension are the LSQ's job.
- **Completion pipeline.**
  - `LATENCY`-stage shift register of {valid, tag, data}; stage 0 is loaded at the acceptance edge.
  - The last stage drives the outputs.
  - Completion order equals acceptance order, at most one completion per cycle.
- **Ordering.** Only one command exists per cycle. A load accepted in any cycle after a store's acceptance sees that store's data.

## Timing
- Command presented in cycle N → `mem_response_o` valid combinationally in cycle N.
  - The LSQ samples it in cycle N.
  - Holding the command into N+1 is a new command.
- Accepted in cycle N → `mem_valid_o` = 1 with its tag and data throughout cycle N+`LATENCY`, then deasserts unless a later completion follows.
- Back-to-back accepts in N, N+1 → completions in N+L and N+L+1.
- **Reset values** (`reset` high at an edge):
  - `mem_valid_o`=0, `mem_tag_o`=0, `mem_data_o`=0; all pipeline stages invalid; `next_tag`=1; array cleared to 0; LFSR reseeded.
  - `mem_response_o` is forced to 0 while `reset` is high.
- **Reset mid-operation.** In-flight completions are dropped; none appear after reset.
- **Reset and command in the same cycle.** The command is not accepted.

## Configuration
- `MEM_RESPONDER_STALL_EN` defined:
  - 16-bit Fibonacci LFSR, seed 16'hACE1, taps 16,14,13,11, advances every cycle when not in reset.
  - Any otherwise-acceptable command is rejected when `lfsr[2:0]` = 3'b000.
  - Rejection has no side effects, and `next_tag` does not advance.
- Undefined: no LFSR is instantiated; every legal command is accepted.

## Test plan
- **Reset.** Assert `reset` 2 cycles with LOAD on the inputs → `mem_response_o`=0, `mem_valid_o`=0, `mem_tag_o`=0, `mem_data_o`=0 throughout.
- **Store then load.**
  - STORE DOUBLE 64'h1122334455667788 @0x100 → response 1; cycle +4: valid, tag 1, data 0.
  - Then LOAD DOUBLE @0x100 → response 2; cycle +4: valid, tag 2, data 64'h1122334455667788.
- **Byte merge.** After the above, STORE BYTE wdata 64'hAB @0x103, then LOAD @0x100 → data 64'h11223344AB667788.
- **Illegal commands.** Each returns response 0 with no completion and no array change:
  - WORD @0x106;
  - HALF @0x101;
  - command 3;
  - size 5.
- **Tag wrap.** 16 consecutive legal LOADs → responses 1..15 then 1; 16 completions in consecutive cycles, in the same tag order.
- **Reset mid-flight.** Reset 2 cycles after accepting 2 loads → no `mem_valid_o` ever; the next accept gets tag 1. With `MEM_RESPONDER_STALL_EN`, 200 random loads → every rejection coincides with `lfsr[2:0]`=0 and tags stay contiguous.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: behavioural memory responder for the LSQ memory port.
//   Accepts LOAD/STORE commands. Each accepted command is answered in the same
//   cycle with a nonzero 4-bit tag. Its completion is returned LATENCY cycles
//   later on the tagged response bus. The responder backs a DEPTH x 64-bit
//   doubleword array.
// Parameters: DEPTH (doublewords, power of 2), LATENCY (1..15), XLEN (address width).
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   mem_command_i      0 NONE, 1 LOAD, 2 STORE, 3 reserved
//   mem_address_i      byte address (bits above the index are ignored)
//   mem_wdata_i        right-aligned store data
//   mem_size_i         0 BYTE, 1 HALF, 2 WORD, 3 DOUBLE
//   mem_response_o     combinational tag of the accepted command, 0 = rejected
//   mem_valid_o        registered completion strobe
//   mem_tag_o          tag of the completing command (0 when idle)
//   mem_data_o         full aligned doubleword for loads, 0 otherwise
// Optional feature: define MEM_RESPONDER_STALL_EN to add LFSR-driven random
// rejection of otherwise-legal commands.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4,
    parameter int XLEN    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mem_command_i,
    input  logic [XLEN-1:0] mem_address_i,
    input  logic [63:0]     mem_wdata_i,
    input  logic [2:0]      mem_size_i,
    output logic [3:0]      mem_response_o,
    output logic            mem_valid_o,
    output logic [3:0]      mem_tag_o,
    output logic [63:0]     mem_data_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [63:0] mem_q [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [2:0]       off;
    logic             legal, aligned, stall, accept, wr_en;
    logic [7:0]       size_mask, be;
    logic [63:0]      wdata_sh, rd_word, wr_word_d;

    logic [3:0]                    next_tag_q, next_tag_d;
    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [LATENCY-1:0][3:0]       tag_q, tag_d;
    logic [LATENCY-1:0][63:0]      data_q, data_d;

    // Address bits above the index only cause wrap-around.
    logic unused_addr;
    assign unused_addr = ^mem_address_i[XLEN-1:3+IDX_W];

    assign idx     = mem_address_i[3 +: IDX_W];
    assign off     = mem_address_i[2:0];
    assign rd_word = mem_q[idx];

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        size_mask = 8'h00;
        aligned   = 1'b0;
        case (mem_size_i)
            3'd0: begin size_mask = 8'h01; aligned = 1'b1;               end
            3'd1: begin size_mask = 8'h03; aligned = (off[0] == 1'b0);   end
            3'd2: begin size_mask = 8'h0F; aligned = (off[1:0] == 2'b0); end
            3'd3: begin size_mask = 8'hFF; aligned = (off == 3'b0);      end
            default: ;
        endcase
        legal  = (mem_command_i == CMD_LOAD || mem_command_i == CMD_STORE) && aligned;
        accept = legal && !stall && !reset;
        wr_en  = accept && (mem_command_i == CMD_STORE);

        // Byte enables and data moved to the addressed lanes.
        be       = size_mask << off;
        wdata_sh = mem_wdata_i << {off, 3'b000};
        for (int b = 0; b < 8; b++)
            wr_word_d[8*b +: 8] = be[b] ? wdata_sh[8*b +: 8] : rd_word[8*b +: 8];
    end

    assign mem_response_o = accept ? next_tag_q : 4'd0;

    always_comb begin
        next_tag_d = next_tag_q;
        if (accept) next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;

        // Stage 0 takes the new command. Bubbles carry zero tag and data, so the
        // last stage can drive the outputs directly.
        vld_d     = vld_q;
        tag_d     = tag_q;
        data_d    = data_q;
        vld_d[0]  = accept;
        tag_d[0]  = accept ? next_tag_q : 4'd0;
        data_d[0] = (accept && mem_command_i == CMD_LOAD) ? rd_word : 64'd0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            tag_d[i]  = tag_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_tag_q <= 4'd1;
            vld_q      <= '0;
            tag_q      <= '0;
            data_q     <= '0;
        end else begin
            next_tag_q <= next_tag_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'd0;
        end else if (wr_en) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    assign mem_valid_o = vld_q[LATENCY-1];
    assign mem_tag_o   = tag_q[LATENCY-1];
    assign mem_data_o  = data_q[LATENCY-1];
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic [63:0] addr, wdata;
    logic [2:0]  size;
    logic [3:0]  resp;
    logic        valid;
    logic [3:0]  tag;
    logic [63:0] data;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .XLEN(64)) dut (
        .clk(clk), .reset(reset), .mem_command_i(cmd), .mem_address_i(addr),
        .mem_wdata_i(wdata), .mem_size_i(size), .mem_response_o(resp),
        .mem_valid_o(valid), .mem_tag_o(tag), .mem_data_o(data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a plain byte-addressable view of the array, a queue of
    // pending completions with their due cycle, and the tag counter.
    typedef struct { int due; logic [3:0] tag; logic [63:0] data; } cpl_t;
    cpl_t        pend[$];
    logic [7:0]  mbytes [DEPTH*8];
    int          cyc = 0;
    int          ntag = 1;
    bit          inited = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    // Values sampled in the most recent applied cycle.
    logic [3:0]  s_resp, s_tag;
    logic        s_valid;
    logic [63:0] s_data;

    typedef struct {
        logic [1:0] cmd; logic [63:0] addr; logic [63:0] wdata; logic [2:0] size;
        logic [3:0] exp_resp; logic [63:0] exp_data;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check against the model, then step the clock.
    task automatic apply(input logic [1:0] c, input logic [63:0] a, input logic [63:0] w,
                         input logic [2:0] s, input logic r);
        bit          acc, stall, exp_v;
        int          base, nb;
        logic [63:0] dw;
        reset = r; cmd = c; addr = a; wdata = w; size = s;
        #2;
        s_resp = resp; s_valid = valid; s_tag = tag; s_data = data;

`ifdef MEM_RESPONDER_STALL_EN
        stall = (m_lfsr[2:0] == 3'b000);
`else
        stall = 1'b0;
`endif
        nb  = 1 << s;
        acc = !r && (c == 2'd1 || c == 2'd2) && (s <= 3'd3) && ((a % nb) == 0) && !stall;
        chk("response", resp, acc ? 64'(ntag) : 64'd0);

        if (inited) begin
            exp_v = (pend.size() > 0) && (pend[0].due == cyc);
            chk("valid", valid, exp_v);
            chk("tag",   tag,   exp_v ? pend[0].tag  : 4'd0);
            chk("data",  data,  exp_v ? pend[0].data : 64'd0);
            if (exp_v) void'(pend.pop_front());
        end

        if (acc) begin
            base = int'((a >> 3) % DEPTH) * 8;
            for (int b = 0; b < 8; b++) dw[8*b +: 8] = mbytes[base + b];
            pend.push_back('{due: cyc + LAT, tag: 4'(ntag), data: (c == 2'd1) ? dw : 64'd0});
            if (c == 2'd2)
                for (int b = 0; b < nb; b++) mbytes[base + int'(a[2:0]) + b] = w[8*b +: 8];
            ntag = (ntag == 15) ? 1 : ntag + 1;
        end

        @(posedge clk);
        cyc++;
        if (r) begin
            pend.delete();
            foreach (mbytes[i]) mbytes[i] = 8'h00;
            ntag   = 1;
            m_lfsr = 16'hACE1;
            inited = 1;
        end else begin
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(2'd0, 64'd0, 64'd0, 3'd0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{2'd2, 64'h100, 64'h1122334455667788, 3'd3, 4'd1, 64'd0};
        tbl[1] = '{2'd1, 64'h100, 64'd0,                3'd3, 4'd2, 64'h1122334455667788};
        tbl[2] = '{2'd2, 64'h103, 64'h00000000000000AB, 3'd0, 4'd3, 64'd0};
        tbl[3] = '{2'd1, 64'h100, 64'd0,                3'd3, 4'd4, 64'h11223344AB667788};
        tbl[4] = '{2'd1, 64'h106, 64'd0,                3'd2, 4'd0, 64'd0};
        tbl[5] = '{2'd2, 64'h101, 64'hFFFF,             3'd1, 4'd0, 64'd0};
        tbl[6] = '{2'd3, 64'h100, 64'hDEAD,             3'd3, 4'd0, 64'd0};
        tbl[7] = '{2'd1, 64'h100, 64'd0,                3'd5, 4'd0, 64'd0};
        tbl[8] = '{2'd1, 64'h100, 64'd0,                3'd3, 4'd5, 64'h11223344AB667788};

        reset = 1'b1; cmd = 2'd0; addr = '0; wdata = '0; size = '0;
        #1;

        // Reset held with a LOAD on the inputs.
        for (int i = 0; i < 2; i++) begin
            apply(2'd1, 64'h100, 64'd0, 3'd3, 1'b1);
            chk("reset_resp", s_resp, 64'd0);
        end
        chk("reset_valid", valid, 1'b0);
        chk("reset_tag",   tag,   4'd0);
        chk("reset_data",  data,  64'd0);

        // Directed vectors, one at a time, each observed at its completion slot.
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, tbl[i].size, 1'b0);
`ifndef MEM_RESPONDER_STALL_EN
            chk($sformatf("tbl%0d_resp", i), s_resp, tbl[i].exp_resp);
`endif
            idle(LAT - 1);
            apply(2'd0, 64'd0, 64'd0, 3'd0, 1'b0);
`ifndef MEM_RESPONDER_STALL_EN
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].exp_resp != 4'd0);
            chk($sformatf("tbl%0d_tag", i),   s_tag,   tbl[i].exp_resp);
            chk($sformatf("tbl%0d_data", i),  s_data,  tbl[i].exp_data);
`endif
        end

        // Tag wrap: 16 back-to-back loads after a fresh reset.
        apply(2'd0, 64'd0, 64'd0, 3'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            apply(2'd1, 64'(i * 8), 64'd0, 3'd3, 1'b0);
`ifndef MEM_RESPONDER_STALL_EN
            chk($sformatf("wrap_resp%0d", i), s_resp, 64'((i % 15) + 1));
`endif
        end
        idle(LAT + 1);
        chk("wrap_drained", pend.size(), 64'd0);

        // Reset two cycles after two accepted loads: nothing completes.
        idle(3);
        apply(2'd1, 64'h40, 64'd0, 3'd3, 1'b0);
        apply(2'd1, 64'h48, 64'd0, 3'd3, 1'b0);
        apply(2'd0, 64'd0, 64'd0, 3'd0, 1'b1);
        apply(2'd0, 64'd0, 64'd0, 3'd0, 1'b1);
        for (int i = 0; i < LAT + 2; i++) begin
            apply(2'd0, 64'd0, 64'd0, 3'd0, 1'b0);
            chk("midreset_no_valid", s_valid, 1'b0);
        end
`ifndef MEM_RESPONDER_STALL_EN
        apply(2'd1, 64'h40, 64'd0, 3'd3, 1'b0);
        chk("midreset_tag1", s_resp, 64'd1);
`endif

        // Randomized traffic, low index bits kept small so loads hit stores.
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  rs;
            logic [63:0] ra;
            rs = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            ra = {32'($urandom), 32'($urandom_range(0, 63))};
            apply(2'($urandom_range(0, 3)), ra, {32'($urandom), 32'($urandom)}, rs, 1'b0);
        end

`ifdef MEM_RESPONDER_STALL_EN
        // Stall mode: a long run of legal loads.
        for (int i = 0; i < 200; i++)
            apply(2'd1, 64'($urandom_range(0, 255)) << 3, 64'd0, 3'd3, 1'b0);
`endif
        idle(LAT + 1);
        chk("final_drained", pend.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
